// File: rtl/epd_pkg.sv
// Shared constants and types for the e-paper panel responder model.
// Command codes, busy-counter sizing and the bundle of synchronized panel pins.
package epd_pkg;

  localparam logic [7:0] CMD_SWRESET   = 8'h12;
  localparam logic [7:0] CMD_ACTIVATE  = 8'h20;
  localparam logic [7:0] CMD_WRITE_RAM = 8'h24;

  localparam int BUSY_CNT_W = 32;

  localparam logic [BUSY_CNT_W-1:0] DEF_BUSY_CYCLES     = 32'd1000;
  localparam logic [BUSY_CNT_W-1:0] DEF_RST_BUSY_CYCLES = 32'd200;

  typedef struct packed {
    logic sclk;
    logic mosi;
    logic cs_n;
    logic dc;
    logic rst_n;
  } epd_pins_t;

  // Idle levels: chip deselected and panel out of reset, so no edge fires on reset release.
  localparam epd_pins_t PINS_IDLE = '{sclk: 1'b0, mosi: 1'b0, cs_n: 1'b1, dc: 1'b0, rst_n: 1'b1};

  function automatic logic [BUSY_CNT_W-1:0] busy_max(input logic [BUSY_CNT_W-1:0] a,
                                                     input logic [BUSY_CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/epd_in_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs, followed by a
// registered level plus registered rising/falling edge strobes that are mutually aligned.
module epd_in_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // prev_q carries the level that the edge strobes were computed against,
  // so a data bit sampled on a rise strobe is the value present at that SCLK edge.
  assign lvl  = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/epd_panel_responder.sv
// Panel-side model of the EPD 4-wire SPI + BUSY interface: deserializes bytes,
// tags them command/data via DC and holds BUSY for programmed durations.
module epd_panel_responder #(
  parameter logic [31:0] BUSY_CYCLES     = epd_pkg::DEF_BUSY_CYCLES,
  parameter logic [31:0] RST_BUSY_CYCLES = epd_pkg::DEF_RST_BUSY_CYCLES,
  parameter logic [7:0]  CMD_SWRESET     = epd_pkg::CMD_SWRESET,
  parameter logic [7:0]  CMD_ACTIVATE    = epd_pkg::CMD_ACTIVATE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        epd_dc,
  input  logic        epd_rst_n,
  output logic        epd_busy,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_cmd,
  output logic [15:0] cmd_count
);

  import epd_pkg::*;

  epd_pins_t pins_raw, pins_lvl, pins_rise, pins_fall;

  assign pins_raw = '{sclk: spi_sclk, mosi: spi_mosi, cs_n: spi_cs_n, dc: epd_dc, rst_n: epd_rst_n};

  epd_in_sync #(
    .W       ($bits(epd_pins_t)),
    .RST_VAL (PINS_IDLE)
  ) u_in_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pins_raw),
    .lvl     (pins_lvl),
    .rise    (pins_rise),
    .fall    (pins_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{pins_fall, pins_rise.mosi, pins_rise.cs_n, pins_rise.dc};

  logic [6:0]            shreg_q,       shreg_d;
  logic [2:0]            bit_cnt_q,     bit_cnt_d;
  logic                  byte_valid_q,  byte_valid_d;
  logic [7:0]            byte_data_q,   byte_data_d;
  logic                  byte_is_cmd_q, byte_is_cmd_d;
  logic [15:0]           cmd_count_q,   cmd_count_d;
  logic [BUSY_CNT_W-1:0] busy_cnt_q,    busy_cnt_d;

  logic panel_in_reset;
  logic trig_load;
  logic rst_load;

  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    byte_is_cmd_d = byte_is_cmd_q;
    cmd_count_d   = cmd_count_q;
    busy_cnt_d    = busy_cnt_q;

    panel_in_reset = ~pins_lvl.rst_n;
    rst_load       = pins_rise.rst_n;
    trig_load      = byte_valid_q & byte_is_cmd_q &
                     ((byte_data_q == CMD_SWRESET) || (byte_data_q == CMD_ACTIVATE));

    if (panel_in_reset || pins_lvl.cs_n) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (pins_rise.sclk) begin
      shreg_d   = {shreg_q[5:0], pins_lvl.mosi};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d  = 1'b1;
        byte_data_d   = {shreg_q, pins_lvl.mosi};
        byte_is_cmd_d = ~pins_lvl.dc;
        if (!pins_lvl.dc) begin
          cmd_count_d = cmd_count_q + 16'd1;
        end
      end
    end

    if (trig_load && rst_load) begin
      busy_cnt_d = busy_max(BUSY_CYCLES, RST_BUSY_CYCLES);
    end else if (trig_load) begin
      busy_cnt_d = BUSY_CYCLES;
    end else if (rst_load) begin
      busy_cnt_d = RST_BUSY_CYCLES;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BUSY_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      byte_is_cmd_q <= 1'b0;
      cmd_count_q   <= '0;
      busy_cnt_q    <= '0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      byte_is_cmd_q <= byte_is_cmd_d;
      cmd_count_q   <= cmd_count_d;
      busy_cnt_q    <= busy_cnt_d;
    end
  end

  // The release strobe keeps BUSY up for the one cycle before the reset load lands in the counter.
  assign epd_busy    = (busy_cnt_q != '0) | ~pins_lvl.rst_n | pins_rise.rst_n;
  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_is_cmd = byte_is_cmd_q;
  assign cmd_count   = cmd_count_q;

endmodule
